// File: rtl/sram_responder.sv
// Async-SRAM style slave (2^ADDR_W x 16) on a shared tri-state bus; SRAM_RESP_CHECK_EN adds a sticky protocolError.
// Read data drives READ_LAT edges after the read sample (sample edge included); no backpressure, one access per enable-low pulse.
module sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] memAddrBus,
  inout  wire  [15:0] memDataBus,
  input  logic        memEnable,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [15:0] accessCount,
  output logic        protocolError
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_in;
  logic [2:0]        r_lat;
  logic [2:0]        w_lat_next;
  logic [15:0]       r_count;
  logic              w_rd_cmd;
  logic              w_wr_cmd;
  logic              w_wr_active;
  logic              w_conflict;
  logic              w_store;
  logic              w_count_inc;
  logic              w_start_read;
  logic              w_load_addr;
  logic              w_drive;
  logic              w_unused_addr;

  assign w_addr_in     = memAddrBus[ADDR_W-1:0];
  assign w_unused_addr = ^memAddrBus;
  assign w_rd_cmd      = !memEnable && !memRead  &&  memWrite;
  assign w_wr_cmd      = !memEnable && !memWrite &&  memRead;
  assign w_conflict    = !memEnable && !memRead  && !memWrite;
  assign w_wr_active   = !memEnable && !memWrite;

  always_comb begin
    w_next       = r_state;
    w_lat_next   = r_lat;
    w_store      = 1'b0;
    w_count_inc  = 1'b0;
    w_start_read = 1'b0;
    w_load_addr  = 1'b0;
    if (memEnable || w_conflict) begin
      w_next     = IDLE;
      w_lat_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_cmd) begin
            w_store     = 1'b1;
            w_count_inc = 1'b1;
            w_next      = WR_HOLD;
          end else if (w_rd_cmd) begin
            w_start_read = 1'b1;
          end
        end
        RD_WAIT: begin
          if (!w_rd_cmd) begin
            w_next     = IDLE;
            w_lat_next = '0;
          end else if (r_lat <= 3'd1) begin
            w_next      = RD_DRIVE;
            w_lat_next  = '0;
            w_count_inc = 1'b1;
          end else begin
            w_lat_next = r_lat - 3'd1;
          end
        end
        RD_DRIVE: begin
          if (!w_rd_cmd) begin
            w_next = IDLE;
          end else if (w_addr_in != r_addr) begin
            w_start_read = 1'b1;
          end
        end
        WR_HOLD: begin
          if (!w_wr_cmd) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
    // A new address while driving is treated exactly like a fresh read from IDLE.
    if (w_start_read) begin
      w_load_addr = 1'b1;
      w_lat_next  = LAT_M1;
      if (READ_LAT == 1) begin
        w_next      = RD_DRIVE;
        w_count_inc = 1'b1;
      end else begin
        w_next = RD_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_addr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_lat   <= w_lat_next;
      if (w_load_addr) r_addr <= w_addr_in;
      if (w_count_inc) r_count <= r_count + 16'd1;
    end
  end

  // Storage has no reset so contents survive rst; writes are blocked while rst is low.
  always_ff @(posedge clk) begin
    if (w_store && rst) r_mem[w_addr_in] <= memDataBus;
  end

  assign w_drive     = (r_state == RD_DRIVE) && !w_wr_active;
  assign memDataBus  = w_drive ? r_mem[r_addr] : 16'hzzzz;
  assign accessCount = r_count;

`ifdef SRAM_RESP_CHECK_EN
  logic r_perr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_perr <= 1'b0;
    else if (w_conflict) r_perr <= 1'b1;
  end
  assign protocolError = r_perr;
`else
  assign protocolError = 1'b0;
`endif

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 10, sets the number of implemented word-address bits (array depth 2^ADDR_W x 16).
REQ-002 Parameter READ_LAT, default 1, legal range 1..7, is the number of clock edges from read-command sample to data drive.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 memAddrBus  input  18  word address from the memory controller.
REQ-006 memDataBus  inout  16  shared data bus; sampled on write, driven only during read data phase, else high-Z.
REQ-007 memEnable  input  1  chip enable, active-low.
REQ-008 memRead  input  1  output enable, active-low.
REQ-009 memWrite  input  1  write enable, active-low.
REQ-010 accessCount  output  16  count of completed accesses (reads + writes), wraps 16'hFFFF -> 16'h0000.
REQ-011 protocolError  output  1  sticky flag: memRead and memWrite both low while memEnable low.

Function
REQ-012 States: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD.
REQ-013 Command sampled each rising edge: read = enable low, read low, write high; write = enable low, write low, read high; otherwise none.
REQ-014 Address used = memAddrBus[ADDR_W-1:0]; upper bits ignored (aliasing, address 2^ADDR_W maps to 0).
REQ-015 IDLE + write: store memDataBus into array[addr] on that edge, increment accessCount, go WR_HOLD.
REQ-016 WR_HOLD: no further store until write command absent for one sampled edge, then IDLE; one store per write-enable low pulse.
REQ-017 IDLE + read: latch addr, load latency counter with READ_LAT-1; if READ_LAT=1 go RD_DRIVE directly, else RD_WAIT.
REQ-018 RD_WAIT: decrement counter each edge; at zero go RD_DRIVE; read command lost -> IDLE, no count.
REQ-019 RD_DRIVE: drive array[latched addr] on memDataBus; increment accessCount once on entry.
REQ-020 RD_DRIVE: read command lost -> release bus same edge, IDLE; address change with read held -> release bus, restart latency as new read.
REQ-021 Bus driven only in RD_DRIVE; never driven in the same cycle a write is sampled.
REQ-022 Any state + memEnable high sampled -> IDLE, bus released.
REQ-023 Both memRead and memWrite low with enable low: no array access, return to IDLE, bus released (protocolError per REQ-030).
REQ-024 accessCount increments by at most 1 per clock.

Reset
REQ-025 rst low asynchronously forces IDLE and releases memDataBus to high-Z within the same cycle.
REQ-026 Reset values: accessCount = 16'h0000, protocolError = 0, latency counter = 0.
REQ-027 Array contents are not cleared by reset and are retained across it.
REQ-028 Reset asserted mid-read aborts it with no count; mid-write, a store already taken on a prior edge is retained.
REQ-029 First command is sampled on the first rising edge after rst returns high.

Configuration
REQ-030 Macro SRAM_RESP_CHECK_EN defined: a REQ-023 conflict sets protocolError on that edge, held until reset.
REQ-031 SRAM_RESP_CHECK_EN undefined: protocolError tied to 0; conflict behaviour per REQ-023 unchanged.

Verification
REQ-032 Write 16'hA5C3 to addr 18'h00012, then read addr 18'h00012 with READ_LAT=1 -> bus = 16'hA5C3 one edge after read sample; accessCount = 2.
REQ-033 READ_LAT=3, read addr 0 holding 16'h1234 -> bus high-Z for 2 edges, 16'h1234 from 3rd edge; memRead high -> high-Z next edge.
REQ-034 ADDR_W=10: write 16'hBEEF to 18'h00400, read 18'h00000 -> 16'hBEEF (aliasing).
REQ-035 Write enable held low 5 cycles with data changing each cycle -> only first value stored; accessCount +1.
REQ-036 With SRAM_RESP_CHECK_EN: enable, read, write all low one cycle -> protocolError = 1 and stays 1, no store, bus high-Z; rst low -> protocolError = 0, array data intact.
REQ-037 rst low during RD_DRIVE -> bus high-Z asynchronously, accessCount = 0.
